axi_lite_mem_arbiter: RTL and testbench
=======================================

Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI-lite memory slave between the instruction fetch unit (read-only master 0) and the load/store unit (read/write master 1).
- Registered round-robin arbitration. Exactly one outstanding transaction at a time.
- The granted master's channels are routed combinationally to the slave; the other master is stalled.
- Sits between the ifu/lsu and the SRAM/crossbar port.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_araddr  in  ADDR_W  IFU read address
- if_arvalid  in  1  IFU read-address valid
- if_arready  out  1  IFU read-address ready
- if_rdata  out  DATA_W  IFU read data
- if_rresp  out  2  IFU read response
- if_rvalid  out  1  IFU read-data valid
- if_rready  in  1  IFU read-data ready
- ls_araddr, ls_arvalid / ls_arready; ls_rdata, ls_rresp, ls_rvalid / ls_rready: LSU read channels, same widths and directions as IFU
- ls_awaddr  in  ADDR_W  LSU write address
- ls_awvalid  in  1  LSU write-address valid
- ls_awready  out  1  LSU write-address ready
- ls_wdata  in  DATA_W  LSU write data
- ls_wstrb  in  DATA_W/8  LSU write strobes
- ls_wvalid  in  1  LSU write-data valid
- ls_wready  out  1  LSU write-data ready
- ls_bresp  out  2  LSU write response
- ls_bvalid  out  1  LSU write-response valid
- ls_bready  in  1  LSU write-response ready
- s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready, s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready: slave side, mirrored directions
- grant  out  2  debug: 0 none, 1 IFU read, 2 LSU read, 3 LSU write

Behaviour:
- Reset is synchronous, active-high (rst), on clk. State=IDLE, last=IFU, grant=0.
  - All ready/valid outputs 0 while in IDLE.
  - Data/resp outputs are don't-care but must be driven to 0.
- States: IDLE, IF_RD, LS_RD, LS_WR.
- IDLE arbitration (evaluated every IDLE cycle, result registered; no channel passes in IDLE):
  - Requests: reqI = if_arvalid; reqL = ls_awvalid | ls_arvalid.
  - Only one requests → grant it.
  - Both request → grant the master not equal to `last`.
  - LSU grant goes to LS_WR if ls_awvalid, else LS_RD. Write beats read within the LSU.
  - Arbitration latency: 1 cycle from valid seen in IDLE to first possible slave handshake.
- Granted state routing:
  - Granted master's AR/R (or AW/W/B) are wired combinationally to the slave, both directions.
  - All other master-side readies and valids are forced 0.
  - Slave valids not belonging to the granted channel are ignored; the matching slave ready is forced 0.
- Transaction completion:
  - IF_RD / LS_RD end on s_rvalid & s_rready.
  - LS_WR ends on s_bvalid & s_bready.
  - AW and W may handshake in either order or the same cycle. W handshake before AW is legal.
  - On completion: state→IDLE next cycle, `last` updated to the completing master. No back-to-back grant without an IDLE cycle.
- An address handshake completes at most once per grant. After the AR (or AW/W) handshake the arbiter masks further arvalid/awvalid/wvalid to the slave until completion.
- rresp/bresp are passed through unmodified, including SLVERR/DECERR. Completion does not depend on resp value.
- Master dropping valid before handshake in a granted state (protocol violation): arbiter stays granted; a simulation assertion fires.
- rst mid-transaction: immediate return to IDLE and all outputs to reset values. The slave is reset by the same rst.

Test Plan:
- IFU only: if_arvalid=1 addr 0x80000000, slave rdata 0x00000413 after 2 cycles → if_rvalid with 0x00000413, grant=1 during, 0 one cycle later; LSU readies stay 0.
- Simultaneous IFU read + LSU read after reset (last=IFU) → LSU served first (grant=2), then IFU (grant=1); third simultaneous pair → LSU again. Alternation verified over 8 rounds.
- LSU write: W arrives 2 cycles before AW, wdata 0xDEADBEEF, wstrb 0xF → slave sees exactly one AW and one W handshake, ls_bvalid with bresp=0, state IDLE after B handshake.
- LSU asserts both awvalid and arvalid → write serviced first (grant=3), read next grant (grant=2).
- Slave returns rresp=2 for IFU read → if_rresp=2 passed through, transaction completes normally, next request granted.
- rst asserted while in LS_WR after AW handshake, before B → next cycle grant=0, all ready/valid outputs 0; new IFU read after deassert served normally.

Source files
------------

// File: rtl/axi_lite_mem_arbiter.sv
// Round-robin arbiter sharing one AXI-lite slave between IFU (read) and LSU.
// One transaction in flight; the granted master is routed straight through.
module axi_lite_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   if_araddr,
    input  logic                if_arvalid,
    output logic                if_arready,
    output logic [DATA_W-1:0]   if_rdata,
    output logic [1:0]          if_rresp,
    output logic                if_rvalid,
    input  logic                if_rready,
    input  logic [ADDR_W-1:0]   ls_araddr,
    input  logic                ls_arvalid,
    output logic                ls_arready,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic [1:0]          ls_rresp,
    output logic                ls_rvalid,
    input  logic                ls_rready,
    input  logic [ADDR_W-1:0]   ls_awaddr,
    input  logic                ls_awvalid,
    output logic                ls_awready,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    input  logic                ls_wvalid,
    output logic                ls_wready,
    output logic [1:0]          ls_bresp,
    output logic                ls_bvalid,
    input  logic                ls_bready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   last_ls_q, last_ls_d;
    logic   addr_done_q, addr_done_d;
    logic   w_done_q, w_done_d;
    logic   req_i, req_l;

    assign req_i = if_arvalid;
    assign req_l = ls_awvalid | ls_arvalid;
    assign grant = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_ls_q   <= 1'b0;
            addr_done_q <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ls_q   <= last_ls_d;
            addr_done_q <= addr_done_d;
            w_done_q    <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_ls_d   = last_ls_q;
        addr_done_d = addr_done_q;
        w_done_d    = w_done_q;
        if_arready  = 1'b0;
        if_rdata    = '0;
        if_rresp    = '0;
        if_rvalid   = 1'b0;
        ls_arready  = 1'b0;
        ls_rdata    = '0;
        ls_rresp    = '0;
        ls_rvalid   = 1'b0;
        ls_awready  = 1'b0;
        ls_wready   = 1'b0;
        ls_bresp    = '0;
        ls_bvalid   = 1'b0;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                addr_done_d = 1'b0;
                w_done_d    = 1'b0;
                // On a tie the master that did not finish last wins.
                if (req_i && (!req_l || last_ls_q)) begin
                    state_d = IF_RD;
                end else if (req_l) begin
                    state_d = ls_awvalid ? LS_WR : LS_RD;
                end
            end
            IF_RD: begin
                s_araddr   = if_araddr;
                s_arvalid  = if_arvalid & ~addr_done_q;
                if_arready = s_arready & ~addr_done_q;
                if_rdata   = s_rdata;
                if_rresp   = s_rresp;
                if_rvalid  = s_rvalid;
                s_rready   = if_rready;
                if (s_arvalid && s_arready) addr_done_d = 1'b1;
                if (s_rvalid && s_rready) begin
                    state_d   = IDLE;
                    last_ls_d = 1'b0;
                end
            end
            LS_RD: begin
                s_araddr   = ls_araddr;
                s_arvalid  = ls_arvalid & ~addr_done_q;
                ls_arready = s_arready & ~addr_done_q;
                ls_rdata   = s_rdata;
                ls_rresp   = s_rresp;
                ls_rvalid  = s_rvalid;
                s_rready   = ls_rready;
                if (s_arvalid && s_arready) addr_done_d = 1'b1;
                if (s_rvalid && s_rready) begin
                    state_d   = IDLE;
                    last_ls_d = 1'b1;
                end
            end
            LS_WR: begin
                s_awaddr   = ls_awaddr;
                s_awvalid  = ls_awvalid & ~addr_done_q;
                ls_awready = s_awready & ~addr_done_q;
                s_wdata    = ls_wdata;
                s_wstrb    = ls_wstrb;
                s_wvalid   = ls_wvalid & ~w_done_q;
                ls_wready  = s_wready & ~w_done_q;
                ls_bresp   = s_bresp;
                ls_bvalid  = s_bvalid;
                s_bready   = ls_bready;
                if (s_awvalid && s_awready) addr_done_d = 1'b1;
                if (s_wvalid && s_wready) w_done_d = 1'b1;
                if (s_bvalid && s_bready) begin
                    state_d   = IDLE;
                    last_ls_d = 1'b1;
                end
            end
        endcase
    end

`ifndef SYNTHESIS
    // A granted master must hold its address valid until accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state_q == IF_RD && !addr_done_q && !if_arvalid))
                else $error("arbiter: IFU dropped arvalid while granted");
            assert (!(state_q == LS_RD && !addr_done_q && !ls_arvalid))
                else $error("arbiter: LSU dropped arvalid while granted");
            assert (!(state_q == LS_WR && !addr_done_q && !ls_awvalid))
                else $error("arbiter: LSU dropped awvalid while granted");
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Random/directed bench for axi_lite_mem_arbiter with a memory slave model
// and a transaction-level round-robin reference.
`timescale 1ns/1ps
module tb_axi_lite_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_araddr, ls_araddr, ls_awaddr, ls_wdata;
    logic        if_arvalid, if_rready, ls_arvalid, ls_rready;
    logic        ls_awvalid, ls_wvalid, ls_bready;
    logic [3:0]  ls_wstrb;
    logic        if_arready, if_rvalid, ls_arready, ls_rvalid;
    logic        ls_awready, ls_wready, ls_bvalid;
    logic [31:0] if_rdata, ls_rdata;
    logic [1:0]  if_rresp, ls_rresp, ls_bresp, grant;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [3:0]  s_wstrb;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;

    always #5 clk = ~clk;

    axi_lite_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_araddr(if_araddr), .if_arvalid(if_arvalid), .if_arready(if_arready),
        .if_rdata(if_rdata), .if_rresp(if_rresp), .if_rvalid(if_rvalid),
        .if_rready(if_rready),
        .ls_araddr(ls_araddr), .ls_arvalid(ls_arvalid), .ls_arready(ls_arready),
        .ls_rdata(ls_rdata), .ls_rresp(ls_rresp), .ls_rvalid(ls_rvalid),
        .ls_rready(ls_rready),
        .ls_awaddr(ls_awaddr), .ls_awvalid(ls_awvalid), .ls_awready(ls_awready),
        .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_wvalid(ls_wvalid),
        .ls_wready(ls_wready), .ls_bresp(ls_bresp), .ls_bvalid(ls_bvalid),
        .ls_bready(ls_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready),
        .grant(grant)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h0000_0413 + 32'(i) * 32'h0101_0100;
    endfunction

    // Slave memory model
    logic [31:0] mem [0:255];
    logic        rd_busy, aw_got, w_got;
    logic [7:0]  rd_idx, wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    int          rd_cnt;
    int          aw_hs = 0;
    int          w_hs = 0;
    int          rlat = -1;
    logic        hold_b = 1'b0;
    logic        ar_block = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            s_arready <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
            rd_busy <= 1'b0; rd_cnt <= 0; rd_idx <= '0;
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0; s_bresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; wr_idx <= '0; wr_data <= '0; wr_strb <= '0;
        end else begin
            if (s_arvalid && s_arready) begin
                rd_busy   <= 1'b1;
                rd_idx    <= s_araddr[9:2];
                s_arready <= 1'b0;
                rd_cnt    <= (rlat >= 0) ? rlat : int'($urandom_range(0, 2));
            end else begin
                s_arready <= !rd_busy && !ar_block && ($urandom_range(0, 3) != 0);
            end
            if (rd_busy && !s_rvalid) begin
                if (rd_cnt == 0) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= mem[rd_idx];
                    s_rresp  <= (rd_idx == 8'hFF) ? 2'd2 : 2'd0;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
            if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
                rd_busy  <= 1'b0;
            end
            if (s_awvalid && s_awready) begin
                aw_got <= 1'b1; wr_idx <= s_awaddr[9:2];
                s_awready <= 1'b0; aw_hs <= aw_hs + 1;
            end else begin
                s_awready <= !aw_got && !s_bvalid && ($urandom_range(0, 3) != 0);
            end
            if (s_wvalid && s_wready) begin
                w_got <= 1'b1; wr_data <= s_wdata; wr_strb <= s_wstrb;
                s_wready <= 1'b0; w_hs <= w_hs + 1;
            end else begin
                s_wready <= !w_got && !s_bvalid && ($urandom_range(0, 3) != 0);
            end
            if (aw_got && w_got && !s_bvalid && !hold_b) begin
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                s_bvalid <= 1'b1; s_bresp <= 2'd0;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ls_act = 0;
    always @(negedge clk)
        if (ls_arready | ls_awready | ls_wready | ls_rvalid | ls_bvalid)
            ls_act <= ls_act + 1;

    logic [11:0] hs_vec;
    assign hs_vec = {if_arready, if_rvalid, ls_arready, ls_rvalid, ls_awready,
                     ls_wready, ls_bvalid, s_arvalid, s_rready, s_awvalid,
                     s_wvalid, s_bready};

    logic [31:0] ref_mem [0:255];

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic ref_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic if_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] rr, output logic [1:0] g, output int st);
        int n = 0;
        d = '0; rr = '0; g = '0; st = 0;
        @(negedge clk);
        if_araddr = a; if_arvalid = 1'b1; if_rready = 1'b1; #1;
        while (!if_arready && n < 200) begin @(negedge clk); #1; n++; end
        chk("if_ar_wait", 32'(n < 200), 32'd1);
        g = grant; st = cyc;
        @(negedge clk);
        if_arvalid = 1'b0; if_araddr = '0; #1;
        n = 0;
        while (!if_rvalid && n < 200) begin @(negedge clk); #1; n++; end
        chk("if_r_wait", 32'(n < 200), 32'd1);
        d = if_rdata; rr = if_rresp;
        @(negedge clk); #1;
        chk("if_gap_idle", 32'(grant), 32'd0);
        if_rready = 1'b0;
    endtask

    task automatic ls_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] rr, output logic [1:0] g, output int st);
        int n = 0;
        d = '0; rr = '0; g = '0; st = 0;
        @(negedge clk);
        ls_araddr = a; ls_arvalid = 1'b1; ls_rready = 1'b1; #1;
        while (!ls_arready && n < 200) begin @(negedge clk); #1; n++; end
        chk("ls_ar_wait", 32'(n < 200), 32'd1);
        g = grant; st = cyc;
        @(negedge clk);
        ls_arvalid = 1'b0; ls_araddr = '0; #1;
        n = 0;
        while (!ls_rvalid && n < 200) begin @(negedge clk); #1; n++; end
        chk("ls_r_wait", 32'(n < 200), 32'd1);
        d = ls_rdata; rr = ls_rresp;
        @(negedge clk); #1;
        chk("ls_rd_gap_idle", 32'(grant), 32'd0);
        ls_rready = 1'b0;
    endtask

    task automatic ls_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int w_dly, input int aw_dly,
                            output logic [1:0] br, output logic [1:0] g, output int st);
        int n = 0;
        br = '0; g = '0; st = 0;
        @(negedge clk);
        ls_bready = 1'b1;
        fork
            begin
                int k = 0;
                repeat (w_dly) @(negedge clk);
                ls_wdata = d; ls_wstrb = s; ls_wvalid = 1'b1; #1;
                while (!ls_wready && k < 200) begin @(negedge clk); #1; k++; end
                chk("ls_w_wait", 32'(k < 200), 32'd1);
                @(negedge clk);
                ls_wvalid = 1'b0;
            end
            begin
                int k = 0;
                repeat (aw_dly) @(negedge clk);
                ls_awaddr = a; ls_awvalid = 1'b1; #1;
                while (!ls_awready && k < 200) begin @(negedge clk); #1; k++; end
                chk("ls_aw_wait", 32'(k < 200), 32'd1);
                g = grant; st = cyc;
                @(negedge clk);
                ls_awvalid = 1'b0;
            end
        join
        #1;
        while (!ls_bvalid && n < 200) begin @(negedge clk); #1; n++; end
        chk("ls_b_wait", 32'(n < 200), 32'd1);
        br = ls_bresp;
        @(negedge clk); #1;
        chk("ls_wr_gap_idle", 32'(grant), 32'd0);
        ls_bready = 1'b0;
    endtask

    function automatic logic [31:0] waddr(input int idx);
        return 32'h8000_0000 + 32'(idx) * 32'd4;
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2, wd;
        logic [1:0]  r, r2, g, g2;
        logic [3:0]  ws;
        int          st, st2, a0, w0, act0, ia, la, kind;
        logic        doi, first_ls, last_ls;

        if_araddr = '0; if_arvalid = 1'b0; if_rready = 1'b0;
        ls_araddr = '0; ls_arvalid = 1'b0; ls_rready = 1'b0;
        ls_awaddr = '0; ls_awvalid = 1'b0; ls_wdata = '0; ls_wstrb = '0;
        ls_wvalid = 1'b0; ls_bready = 1'b0;
        ref_init();
        last_ls = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_hs_zero", 32'(hs_vec), 32'd0);
        rst = 1'b0;

        // IFU only, with one-cycle arbitration latency visible
        ar_block = 1'b1; rlat = 1; act0 = ls_act;
        @(negedge clk);
        if_araddr = 32'h8000_0000; if_arvalid = 1'b1; #1;
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_no_pass", 32'({if_arready, s_arvalid}), 32'd0);
        @(negedge clk); #1;
        chk("arb_lat_grant", 32'(grant), 32'd1);
        chk("arb_lat_sarvalid", 32'(s_arvalid), 32'd1);
        ar_block = 1'b0;
        if_read(32'h8000_0000, d, r, g, st);
        chk("ifo_data", d, 32'h0000_0413);
        chk("ifo_resp", 32'(r), 32'd0);
        chk("ifo_grant", 32'(g), 32'd1);
        chk("ifo_ls_quiet", 32'(ls_act - act0), 32'd0);
        rlat = -1; last_ls = 1'b0;

        // Simultaneous IFU + LSU reads
        for (int k = 0; k < 8; k++) begin
            ia = $urandom_range(0, 15); la = $urandom_range(0, 15);
            fork
                if_read(waddr(ia), d, r, g, st);
                ls_read(waddr(la), d2, r2, g2, st2);
            join
            first_ls = !last_ls;
            chk("rr_if_data", d, ref_mem[ia]);
            chk("rr_ls_data", d2, ref_mem[la]);
            chk("rr_if_grant", 32'(g), 32'd1);
            chk("rr_ls_grant", 32'(g2), 32'd2);
            chk("rr_order", 32'(st2 < st), 32'(first_ls));
            last_ls = !first_ls;
        end

        // W two cycles ahead of AW
        a0 = aw_hs; w0 = w_hs;
        ls_write(waddr(8), 32'hDEAD_BEEF, 4'hF, 0, 2, r, g, st);
        ref_write(8, 32'hDEAD_BEEF, 4'hF);
        chk("wfirst_aw_count", 32'(aw_hs - a0), 32'd1);
        chk("wfirst_w_count", 32'(w_hs - w0), 32'd1);
        chk("wfirst_bresp", 32'(r), 32'd0);
        chk("wfirst_grant", 32'(g), 32'd3);
        ls_read(waddr(8), d, r, g, st);
        chk("wfirst_readback", d, 32'hDEAD_BEEF);
        last_ls = 1'b1;

        // LSU write and read presented together
        wd = $urandom; ws = 4'($urandom_range(1, 15));
        fork
            ls_write(waddr(9), wd, ws, 0, 0, r, g, st);
            ls_read(waddr(9), d2, r2, g2, st2);
        join
        ref_write(9, wd, ws);
        chk("awar_wr_grant", 32'(g), 32'd3);
        chk("awar_rd_grant", 32'(g2), 32'd2);
        chk("awar_wr_first", 32'(st < st2), 32'd1);
        chk("awar_rd_data", d2, ref_mem[9]);
        last_ls = 1'b1;

        // Error response pass-through
        if_read(waddr(255), d, r, g, st);
        chk("slverr_resp", 32'(r), 32'd2);
        chk("slverr_data", d, ref_mem[255]);
        if_read(waddr(1), d, r, g, st);
        chk("after_err_grant", 32'(g), 32'd1);
        chk("after_err_resp", 32'(r), 32'd0);
        chk("after_err_data", d, ref_mem[1]);
        last_ls = 1'b0;

        // Random mix against the round-robin model
        for (int k = 0; k < 24; k++) begin
            doi = 1'($urandom_range(0, 1)); kind = $urandom_range(0, 2);
            if (!doi && kind == 0) doi = 1'b1;
            ia = $urandom_range(0, 7); la = $urandom_range(8, 15);
            wd = $urandom; ws = 4'($urandom_range(1, 15));
            fork
                begin
                    if (doi) if_read(waddr(ia), d, r, g, st);
                end
                begin
                    if (kind == 1) ls_read(waddr(la), d2, r2, g2, st2);
                    else if (kind == 2)
                        ls_write(waddr(la), wd, ws, int'($urandom_range(0, 2)), 0,
                                 r2, g2, st2);
                end
            join
            first_ls = (kind != 0) && (!doi || !last_ls);
            if (doi) begin
                chk("rnd_if_data", d, ref_mem[ia]);
                chk("rnd_if_grant", 32'(g), 32'd1);
            end
            if (kind == 1) begin
                chk("rnd_ls_data", d2, ref_mem[la]);
                chk("rnd_ls_grant", 32'(g2), 32'd2);
            end
            if (kind == 2) begin
                chk("rnd_wr_grant", 32'(g2), 32'd3);
                chk("rnd_wr_bresp", 32'(r2), 32'd0);
                ref_write(la, wd, ws);
            end
            if (doi && kind != 0) chk("rnd_order", 32'(st2 < st), 32'(first_ls));
            last_ls = (doi && kind != 0) ? !first_ls : (kind != 0);
        end
        for (int i = 8; i < 16; i++) begin
            ls_read(waddr(i), d, r, g, st);
            chk("final_mem", d, ref_mem[i]);
        end
        last_ls = 1'b1;

        // Reset in the middle of a write, B held back by the slave
        hold_b = 1'b1; a0 = aw_hs; w0 = w_hs;
        @(negedge clk);
        ls_awaddr = waddr(3); ls_awvalid = 1'b1;
        ls_wdata = 32'h1234_5678; ls_wstrb = 4'hF; ls_wvalid = 1'b1; ls_bready = 1'b1;
        for (int n = 0; n < 200 && !(aw_hs > a0 && w_hs > w0); n++) @(negedge clk);
        chk("rstmid_hs_done", 32'(aw_hs > a0 && w_hs > w0), 32'd1);
        #1;
        chk("rstmid_grant_before", 32'(grant), 32'd3);
        if_arvalid = 1'b1; if_araddr = waddr(2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_hs_zero", 32'(hs_vec), 32'd0);
        chk("rstmid_data_zero", s_awaddr | s_wdata | s_araddr | 32'(s_wstrb), 32'd0);
        @(negedge clk);
        ls_awvalid = 1'b0; ls_wvalid = 1'b0; ls_bready = 1'b0; if_arvalid = 1'b0;
        rst = 1'b0; hold_b = 1'b0;
        ref_init(); last_ls = 1'b0;
        if_read(waddr(4), d, r, g, st);
        chk("post_rst_grant", 32'(g), 32'd1);
        chk("post_rst_data", d, init_word(4));
        ls_read(waddr(3), d, r, g, st);
        chk("post_rst_nowrite", d, init_word(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
